register_bank: RTL and testbench

- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits wide.
- Generalises the CPU's single 8-bit enable-load register:
  - in-place ops: load, clear, increment, decrement, shift left, shift right;
  - carry/borrow flag;
  - two registered read ports with write-forwarding.
- Sits between the datapath ALU/bus and the control unit; the control unit drives op/address each cycle.

---
 rtl/register_bank_if.sv | 28 ++
 rtl/register_bank.sv | 119 +++++++++++
 tb/tb_register_bank.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// Control/data bundle between the control unit (master) and the register bank (slave).
interface register_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             en;
  logic [2:0]       op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             zero_a;
  logic             carry;

  modport master (
    output en, op, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, zero_a, carry
  );

  modport slave (
    input  en, op, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, zero_a, carry
  );
endinterface

// File: rtl/register_bank.sv
// Bank of DEPTH WIDTH-bit registers with in-place ALU-style ops, a carry flag and two
// registered read ports that forward same-edge updates.
module register_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  register_bank_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpClear = 3'b010;
  localparam logic [2:0] OpInc   = 3'b011;
  localparam logic [2:0] OpDec   = 3'b100;
  localparam logic [2:0] OpShl   = 3'b101;
  localparam logic [2:0] OpShr   = 3'b110;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             zero_a_q, zero_a_d;
  logic             carry_q, carry_d;

  logic [2**AW-1:0] addr_valid;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             apply;

  // Address decode via a map avoids constant-range compares when DEPTH is a power of two.
  always_comb begin
    addr_valid = '0;
    for (int i = 0; i < 2**AW; i++) begin
      addr_valid[i] = (i < DEPTH);
    end
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.waddr == AW'(i)) cur = regs_q[i];
    end

    nxt     = cur;
    apply   = 1'b0;
    carry_d = carry_q;
    if (bus.en && addr_valid[bus.waddr]) begin
      case (bus.op)
        OpLoad: begin
          nxt   = bus.wdata;
          apply = 1'b1;
        end
        OpClear: begin
          nxt     = '0;
          carry_d = 1'b0;
          apply   = 1'b1;
        end
        OpInc: begin
          nxt     = cur + WIDTH'(1);
          carry_d = &cur;
          apply   = 1'b1;
        end
        OpDec: begin
          nxt     = cur - WIDTH'(1);
          carry_d = ~|cur;
          apply   = 1'b1;
        end
        OpShl: begin
          nxt     = {cur[WIDTH-2:0], bus.wdata[0]};
          carry_d = cur[WIDTH-1];
          apply   = 1'b1;
        end
        OpShr: begin
          nxt     = {bus.wdata[0], cur[WIDTH-1:1]};
          carry_d = cur[0];
          apply   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read muxes select from the next-state array so same-edge writes are forwarded.
  always_comb begin
    rdata_a_d = '0;
    rdata_b_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (apply && bus.waddr == AW'(i)) ? nxt : regs_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a == AW'(i)) rdata_a_d = regs_d[i];
      if (bus.raddr_b == AW'(i)) rdata_b_d = regs_d[i];
    end
    zero_a_d = (rdata_a_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      zero_a_q  <= 1'b1;
      carry_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      zero_a_q  <= zero_a_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
  assign bus.zero_a  = zero_a_q;
  assign bus.carry   = carry_q;
endmodule

// File: tb/tb_register_bank.sv
// Directed table-driven bench for register_bank: a DEPTH=4 and a DEPTH=3 instance.
module tb_register_bank;
  logic clk;
  logic rst;

  register_bank_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  register_bank_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

  register_bank #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  register_bank #(.WIDTH(8), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] op;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_zero;
    logic       exp_carry;
  } vec_t;

  localparam logic [2:0] NOP = 3'd0, LD = 3'd1, CLR = 3'd2, INC = 3'd3;
  localparam logic [2:0] DEC = 3'd4, SHL = 3'd5, SHR = 3'd6, RSV = 3'd7;

  int total = 0;
  int bad   = 0;

  vec_t tab4 [17];
  vec_t tab3 [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input bit use3);
    if (use3) begin
      bus3.en = v.en; bus3.op = v.op; bus3.waddr = v.waddr; bus3.wdata = v.wdata;
      bus3.raddr_a = v.raddr_a; bus3.raddr_b = v.raddr_b;
    end else begin
      bus4.en = v.en; bus4.op = v.op; bus4.waddr = v.waddr; bus4.wdata = v.wdata;
      bus4.raddr_a = v.raddr_a; bus4.raddr_b = v.raddr_b;
    end
  endtask

  task automatic check_outs(input string tag, input bit use3, input logic [7:0] ea,
                            input logic [7:0] eb, input logic ez, input logic ec);
    if (use3) begin
      check({tag, ".rdata_a"}, bus3.rdata_a, ea);
      check({tag, ".rdata_b"}, bus3.rdata_b, eb);
      check({tag, ".zero_a"}, {7'd0, bus3.zero_a}, {7'd0, ez});
      check({tag, ".carry"}, {7'd0, bus3.carry}, {7'd0, ec});
    end else begin
      check({tag, ".rdata_a"}, bus4.rdata_a, ea);
      check({tag, ".rdata_b"}, bus4.rdata_b, eb);
      check({tag, ".zero_a"}, {7'd0, bus4.zero_a}, {7'd0, ez});
      check({tag, ".carry"}, {7'd0, bus4.carry}, {7'd0, ec});
    end
  endtask

  task automatic apply(input vec_t v, input bit use3, input string tag);
    drive(v, use3);
    @(posedge clk);
    #1;
    check_outs(tag, use3, v.exp_a, v.exp_b, v.exp_zero, v.exp_carry);
  endtask

  function automatic vec_t mk(input logic en, input logic [2:0] op, input logic [1:0] wa,
                              input logic [7:0] wd, input logic [1:0] ra, input logic [1:0] rb,
                              input logic [7:0] ea, input logic [7:0] eb, input logic ez,
                              input logic ec);
    vec_t v;
    v.en = en; v.op = op; v.waddr = wa; v.wdata = wd; v.raddr_a = ra; v.raddr_b = rb;
    v.exp_a = ea; v.exp_b = eb; v.exp_zero = ez; v.exp_carry = ec;
    return v;
  endfunction

  initial begin
    //            en  op   wa  wdata  ra  rb  exp_a  exp_b  z  c
    tab4[0]  = mk(0, NOP, 0, 8'h00, 0, 1, 8'h00, 8'h00, 1, 0);
    tab4[1]  = mk(0, NOP, 0, 8'h00, 2, 3, 8'h00, 8'h00, 1, 0);
    tab4[2]  = mk(1, LD,  2, 8'hA5, 2, 1, 8'hA5, 8'h00, 0, 0);
    tab4[3]  = mk(1, LD,  1, 8'hFF, 1, 2, 8'hFF, 8'hA5, 0, 0);
    tab4[4]  = mk(1, INC, 1, 8'h00, 1, 1, 8'h00, 8'h00, 1, 1);
    tab4[5]  = mk(1, DEC, 1, 8'h00, 1, 2, 8'hFF, 8'hA5, 0, 1);
    tab4[6]  = mk(1, DEC, 1, 8'h00, 1, 1, 8'hFE, 8'hFE, 0, 0);
    tab4[7]  = mk(1, LD,  3, 8'h81, 3, 1, 8'h81, 8'hFE, 0, 0);
    tab4[8]  = mk(1, SHL, 3, 8'h00, 3, 3, 8'h02, 8'h02, 0, 1);
    tab4[9]  = mk(1, SHR, 3, 8'h01, 3, 0, 8'h81, 8'h00, 0, 0);
    tab4[10] = mk(1, SHL, 3, 8'h00, 3, 3, 8'h02, 8'h02, 0, 1);
    tab4[11] = mk(0, INC, 0, 8'h00, 0, 3, 8'h00, 8'h02, 1, 1);
    tab4[12] = mk(1, RSV, 0, 8'h00, 0, 1, 8'h00, 8'hFE, 1, 1);
    tab4[13] = mk(1, NOP, 3, 8'h00, 3, 2, 8'h02, 8'hA5, 0, 1);
    tab4[14] = mk(1, CLR, 3, 8'h00, 3, 1, 8'h00, 8'hFE, 1, 0);
    tab4[15] = mk(1, SHR, 2, 8'h00, 2, 2, 8'h52, 8'h52, 0, 1);
    tab4[16] = mk(1, DEC, 0, 8'h00, 1, 0, 8'hFE, 8'hFF, 0, 1);

    tab3[0]  = mk(1, LD,  2, 8'h3C, 2, 0, 8'h3C, 8'h00, 0, 0);
    tab3[1]  = mk(1, LD,  0, 8'hFF, 0, 2, 8'hFF, 8'h3C, 0, 0);
    tab3[2]  = mk(1, INC, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1);
    tab3[3]  = mk(1, LD,  3, 8'h55, 3, 2, 8'h00, 8'h3C, 1, 1);
    tab3[4]  = mk(1, SHL, 3, 8'h01, 3, 3, 8'h00, 8'h00, 1, 1);
    tab3[5]  = mk(0, NOP, 0, 8'h00, 0, 1, 8'h00, 8'h00, 1, 1);
    tab3[6]  = mk(1, DEC, 3, 8'h00, 2, 0, 8'h3C, 8'h00, 0, 1);
    tab3[7]  = mk(1, DEC, 1, 8'h00, 1, 2, 8'hFF, 8'h3C, 0, 1);

    rst = 1'b0;
    drive(mk(0, NOP, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0), 1'b0);
    drive(mk(0, NOP, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_outs("por", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check_outs("por3", 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) apply(tab4[i], 1'b0, $sformatf("d4v%0d", i));

    // Registers now hold non-zero data and carry=1; reset mid-cycle with a LOAD pending.
    drive(mk(1, LD, 3, 8'h77, 1, 2, 8'h00, 8'h00, 1, 0), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outs("rst_hold", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    apply(mk(0, NOP, 0, 8'h00, 3, 0, 8'h00, 8'h00, 1, 0), 1'b0, "post_rst_a");
    apply(mk(0, NOP, 0, 8'h00, 1, 2, 8'h00, 8'h00, 1, 0), 1'b0, "post_rst_b");

    for (int i = 0; i < 8; i++) apply(tab3[i], 1'b1, $sformatf("d3v%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
